// File: rtl/mips_pkg.sv
// Shared types and field constants for the MIPS fetch stage.
package mips_pkg;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    FETCH      = 2'd1,
    EXEC       = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 26;
  localparam int unsigned JUMP_W = 26;
  localparam int unsigned IMM_W  = 16;

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC select: jump, branch or sequential.
module mips_next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        pcsrc1,
  input  logic        pcsrc2,
  output logic [31:0] next_pc
);

  logic [31:0] jump_target;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic        unused_opc;

  assign jump_target   = {pc_plus4[31:28], instr[JUMP_W-1:0], 2'b00};
  assign branch_offset = {{(XLEN-IMM_W-2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset;
  assign unused_opc    = ^instr[OPC_HI:OPC_LO];

  // Jump (pcsrc2 low) takes precedence over branch.
  always_comb begin
    next_pc = pc_plus4;
    if (!pcsrc2) begin
      next_pc = jump_target;
    end else if (pcsrc1) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Fetch stage: PC register, instruction register and fetch/execute sequencing.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        hold,
  input  logic        pcsrc1,
  input  logic        pcsrc2,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_t state;
  logic [31:0]  next_pc;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign opcode    = instr[OPC_HI:OPC_LO];

  mips_next_pc u_next_pc (
    .pc_plus4 (pc_plus4),
    .instr    (instr),
    .pcsrc1   (pcsrc1),
    .pcsrc2   (pcsrc2),
    .next_pc  (next_pc)
  );

  // imem_req / instr_valid are registered alongside the state so reset clears them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RESET_WAIT;
      pc          <= RESET_PC_ALIGNED;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        RESET_WAIT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            state       <= EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (!hold) begin
            pc          <= next_pc;
            state       <= FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= RESET_WAIT;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit with a behavioural reference model and per-cycle compare.
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        hold = 1'b0;
  logic        pcsrc1 = 1'b0;
  logic        pcsrc2 = 1'b1;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .hold        (hold),
    .pcsrc1      (pcsrc1),
    .pcsrc2      (pcsrc2),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = idle after reset, 1 = waiting for memory, 2 = instruction on offer.
  int          m_phase = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = 32'h0;

  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] ins,
                                             input logic p1, input logic p2);
    logic [31:0] seq;
    int          off;
    seq = cur_pc + 32'd4;
    off = $signed(ins[15:0]);
    if (!p2) return (seq & 32'hF000_0000) | ({6'b0, ins[25:0]} << 2);
    if (p1)  return seq + 32'(off * 4);
    return seq;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_pc    = 32'h0;
      m_instr = 32'h0;
    end else begin
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (imem_ack) begin
          m_instr = imem_rdata;
          m_phase = 2;
        end
      end else if (!hold) begin
        m_pc    = model_next(m_pc, m_instr, pcsrc1, pcsrc2);
        m_phase = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("imem_req", 32'(imem_req), 32'(m_phase == 1));
    check("instr_valid", 32'(instr_valid), 32'(m_phase == 2));
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("imem_addr", imem_addr, m_pc);
    check("instr", instr, m_instr);
    check("opcode", 32'(opcode), 32'(m_instr[31:26]));
  end

  task automatic tick;
    @(negedge clk);
  endtask

  // Entered on the falling edge of the first FETCH cycle; leaves on the first FETCH of the next one.
  task automatic fetch_exec(input logic [31:0] data, input int ack_delay, input int hold_cycles,
                            input logic p1, input logic p2, input logic [31:0] exp_pc);
    logic [31:0] addr0;
    int          req_cycles;
    addr0      = imem_addr;
    req_cycles = 0;
    for (int i = 0; i < ack_delay; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      hold       = 1'b1;
      if (imem_req) req_cycles++;
      tick;
      check("addr_stable", imem_addr, addr0);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    hold       = 1'b0;
    if (imem_req) req_cycles++;
    tick;
    if (ack_delay > 0) check("req_cycles", 32'(req_cycles), 32'(ack_delay + 1));
    check("instr_cap", instr, data);
    check("exec_valid", 32'(instr_valid), 32'd1);
    check("exec_opcode", 32'(opcode), 32'(data[31:26]));
    imem_ack   = (hold_cycles > 0);
    imem_rdata = ~data;
    pcsrc1     = p1;
    pcsrc2     = p2;
    for (int i = 0; i < hold_cycles; i++) begin
      hold = 1'b1;
      tick;
      check("hold_pc", pc, addr0);
      check("hold_instr", instr, data);
      check("hold_req", 32'(imem_req), 32'd0);
    end
    hold     = 1'b0;
    imem_ack = 1'b0;
    tick;
    check("next_pc", pc, exp_pc);
    pcsrc1 = 1'b0;
    pcsrc2 = 1'b1;
  endtask

  initial begin
    repeat (2) tick;
    check("rst_pc", pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    check("rst_instr", instr, 32'h0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    rst = 1'b0;
    check("idle_req", 32'(imem_req), 32'd0);
    tick;
    check("first_req", 32'(imem_req), 32'd1);

    fetch_exec(32'h0000_0020, 0, 0, 1'b0, 1'b1, 32'h0000_0004);
    fetch_exec(32'h0000_0000, 0, 0, 1'b0, 1'b1, 32'h0000_0008);
    fetch_exec(32'h8000_FFFE, 0, 0, 1'b1, 1'b1, 32'h0000_0004);
    fetch_exec(32'h2000_1234, 5, 3, 1'b0, 1'b1, 32'h0000_0008);
    fetch_exec(32'h0BFF_FFFF, 1, 0, 1'b0, 1'b0, 32'h0FFF_FFFC);
    fetch_exec(32'h0000_0000, 0, 0, 1'b0, 1'b1, 32'h1000_0000);
    fetch_exec(32'h1000_0003, 2, 0, 1'b1, 1'b1, 32'h1000_0010);
    fetch_exec(32'h4000_0040, 0, 1, 1'b1, 1'b0, 32'h1000_0100);

    // Reset arriving mid-fetch must clear the request without waiting for a clock.
    imem_ack = 1'b0;
    repeat (2) tick;
    #2 rst = 1'b1;
    #1;
    check("async_req", 32'(imem_req), 32'd0);
    check("async_pc", pc, 32'h0);
    tick;
    rst = 1'b0;
    check("post_rst_req", 32'(imem_req), 32'd0);
    tick;
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", imem_addr, 32'h0);

    fetch_exec(32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    fetch_exec(32'h0000_0000, 0, 0, 1'b0, 1'b1, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction-fetch stage for the single-cycle MIPS datapath, directly upstream of the main controller. Holds the program counter and requests instructions from instruction memory over a request/acknowledge handshake. Presents each fetched instruction (and its opcode field) to the controller for exactly one execute cycle, then updates the PC from that cycle's `pcsrc1`/`pcsrc2` decision.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_req` output 1: instruction-memory read request.
- `imem_addr` output 32: byte address of the requested word; equals `pc`.
- `imem_ack` input 1: memory has valid data on `imem_rdata` this cycle.
- `imem_rdata` input 32: instruction word.
- `hold` input 1: freeze in execute (no PC update, no new fetch).
- `pcsrc1` input 1: from controller; 1 selects the branch target.
- `pcsrc2` input 1: from controller; 0 selects the jump target (overrides `pcsrc1`).
- `pc` output 32: current PC.
- `pc_plus4` output 32: `pc + 4`, the link value for jal.
- `instr` output 32: instruction register.
- `opcode` output 6: `instr[31:26]`, fed to the controller.
- `instr_valid` output 1: high in the execute state.

## Operation
- FSM states: RESET_WAIT, FETCH, EXEC.
- RESET_WAIT is entered on reset and moves to FETCH on the first clock edge. This gives one idle cycle after reset release.
- FETCH:
  - `imem_req`=1, with `imem_addr`=`pc` held stable.
  - On an edge with `imem_ack`=1: `instr` <= `imem_rdata`, go to EXEC.
  - Otherwise stay in FETCH (unbounded wait).
- EXEC:
  - `instr_valid`=1 and `imem_req`=0.
  - If `hold`=1: stay in EXEC; `pc` and `instr` are unchanged.
  - Else: `pc` <= next_pc and go to FETCH.
- next_pc, evaluated in EXEC only:
  - `pcsrc2`=0: jump target `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - `pcsrc2`=1 and `pcsrc1`=1: branch target `pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})`.
  - Otherwise: `pc_plus4`.
- Arithmetic:
  - All 32-bit, modulo 2^32; `pc`=32'hFFFF_FFFC wraps `pc_plus4` to 0.
  - `pc[1:0]` is always 00.
- `imem_ack` is ignored outside FETCH.
- `pcsrc1`/`pcsrc2` are ignored outside EXEC.
- Reset values: `pc`=`RESET_PC`, `instr`=0, `opcode`=0, `instr_valid`=0, `imem_req`=0, `pc_plus4`=`RESET_PC`+4, state RESET_WAIT.
- Reset mid-fetch or mid-exec: `imem_req` and `instr_valid` drop asynchronously. Any outstanding memory response is discarded. No PC update occurs.

## Timing
- `imem_req`, `instr_valid` and `opcode` are decoded from registered state or registers only; there are no combinational paths from inputs.
- The `pcsrc` inputs reach only `pc` through the next-PC logic.
- Ack in the first FETCH cycle gives a minimum of 2 cycles per instruction (1 FETCH + 1 EXEC). Each cycle of ack delay adds 1 cycle.
- `instr` changes only on the FETCH→EXEC edge, so it is stable for the whole EXEC window.
- `pc` changes only on the EXEC→FETCH edge. Therefore `imem_addr` is stable for the whole FETCH window.
- `hold` is sampled at the EXEC clock edge.
  - Deassertion lets the PC update on that same edge.
  - Assertion during FETCH has no effect.
- After reset release: `imem_req` rises in cycle 2, and the earliest `instr_valid` is cycle 3.

## Structure
- Shared package `mips_pkg`:
  - FSM state typedef `fetch_state_t`.
  - Constant `RESET_PC_DEFAULT`.
  - Opcode field positions `OPC_HI`=31 and `OPC_LO`=26.
  - Jump-field and immediate-field widths (26, 16).
- One sub-module, `mips_next_pc`: purely combinational target computation.
  - Inputs: `pc_plus4`, `instr`, `pcsrc1`, `pcsrc2`.
  - Output: next PC.
  - It is instantiated once.
- FSM, PC register, and instruction register live in `mips_fetch_unit`.

## Test plan
- Reset with `RESET_PC`=0 and ack same cycle as req, data 32'h0000_0020 → `opcode`=0 and `instr_valid` in cycle 3; with `pcsrc2`=1, `pcsrc1`=0, PC then becomes 4.
- At `pc`=8, instr 32'h8000_FFFE, `pcsrc1`=1, `pcsrc2`=1 → next `pc`=12+(−8)=4.
- At `pc`=32'h1000_0010, instr 32'h4000_0040, `pcsrc2`=0 → next `pc`=32'h1000_0100.
- Ack delayed 5 cycles with `imem_addr` monitored → address constant, `imem_req` high for 6 cycles, and `instr` captured only on the ack edge. A spurious ack in EXEC is ignored.
- `hold`=1 for 3 EXEC cycles → `pc` and `instr` are frozen and `imem_req`=0; after release the PC updates on the next edge.
- `rst` asserted in a FETCH wait → `imem_req` drops immediately; after release, fetch restarts at `RESET_PC`. Wrap case: `pc`=32'hFFFF_FFFC with sequential flow → next `pc`=0.
